nrzi_unstuff_decoder: RTL and testbench
=======================================

# nrzi_unstuff_decoder

Parametrised NRZI decoder with integrated bit-unstuffing and stuff-error detection for the USB 1.1 receive path. Sits between the line-sampling front end (fed by `d`) and the receive shift register. Decodes one bit per `shift_en` strobe rather than every clock, drops stuffed bits, and flags stuff violations. Keeps a free-running registered edge output so the bit-timing recovery logic can resynchronise on line transitions.

## Interface
- `STUFF_LEN`, default 6: number of consecutive decoded 1s after which the next bit is a stuff bit; legal range 2..15.
- `IDLE_LEVEL`, default 1'b1: line level of bus idle (J); used as NRZI reference after reset or `clear`.
- `clk` input 1: sole clock, rising edge.
- `n_rst` input 1: synchronous, active-low reset.
- `d` input 1: synchronised serial line level.
- `shift_en` input 1: one-cycle strobe marking the bit-centre sample of `d`.
- `clear` input 1: synchronous packet-boundary clear (EOP/idle); re-arms the NRZI reference and run counter.
- `d_orig` output 1: last decoded NRZI bit, held between strobes.
- `d_edge` output 1: registered line-transition flag, every clock.
- `bit_valid` output 1: one-cycle pulse; `d_orig` is a data bit to shift in.
- `stuff_bit` output 1: one-cycle pulse; a correct stuff bit was removed.
- `stuff_err` output 1: one-cycle pulse; stuff position carried a 1.
- `run_cnt` output $clog2(STUFF_LEN+1): current consecutive-ones count, for debug and verification.

## Operation
- Internal state: `q_clk` (previous clock sample of `d`), `prev_bit` (line level at last accepted strobe), run counter.
- Every clock: `q_clk <= d`; `d_edge <= d ^ q_clk`. Not affected by `shift_en` or `clear`.
- On `shift_en` (and no `clear`): decoded bit `b = ~(d ^ prev_bit)`; `prev_bit <= d`; `d_orig <= b`.
  - `run_cnt < STUFF_LEN`: `bit_valid` pulses. `b=1` increments `run_cnt`; `b=0` zeroes it.
  - `run_cnt == STUFF_LEN`, `b=0`: stuff bit. `stuff_bit` pulses, `bit_valid` stays 0, `run_cnt <= 0`.
  - `run_cnt == STUFF_LEN`, `b=1`: violation. `stuff_err` pulses, `bit_valid` stays 0, `run_cnt` holds at `STUFF_LEN`, so each further 1 also errors until a 0 or `clear`.
- `clear`: `prev_bit <= IDLE_LEVEL`, `run_cnt <= 0`. If `shift_en` is high in the same cycle, `clear` wins: the bit is discarded, no strobe outputs pulse, and `d_orig` holds.
- Without a strobe, `d_orig`, `prev_bit` and `run_cnt` hold. `bit_valid`, `stuff_bit` and `stuff_err` are 0.
- `bit_valid`, `stuff_bit` and `stuff_err` are mutually exclusive.

## Timing
- All outputs are registered. For a strobe in cycle N, `d_orig`, `bit_valid`, `stuff_bit`, `stuff_err` and `run_cnt` update at the end of N and are visible in N+1.
- `d_edge` in cycle N+1 reflects `d(N) ^ d(N-1)`.
- Back-to-back strobes (every cycle) are supported at full rate.
- Reset (`n_rst=0` at a rising edge) gives:
  - `d_orig=0`, `d_edge=0`, `bit_valid=0`, `stuff_bit=0`, `stuff_err=0`, `run_cnt=0`
  - `q_clk=IDLE_LEVEL`, `prev_bit=IDLE_LEVEL`
- Reset mid-packet discards any partial run. It takes priority over `clear` and `shift_en`.

## Configuration
- `NRZI_STUFF_CHECK_EN` defined: stuff-error detection as described above.
- `NRZI_STUFF_CHECK_EN` undefined:
  - `stuff_err` is tied to 0.
  - The bit after `STUFF_LEN` ones is always dropped as a stuff bit, whatever its value; `stuff_bit` pulses and `run_cnt <= 0`.

## Test plan
- Reset, then `d=1` with strobes every 4 clocks for 3 bits -> `d_orig=1` and `bit_valid` pulse each bit; `run_cnt` steps 1,2,3; `d_edge=0` throughout.
- Line sequence 1,0,0,1 (one strobe each, `IDLE_LEVEL=1`) -> decoded 1,0,1,0; `d_edge` pulses one clock after each line transition.
- Six decoded 1s then a line toggle at the strobe -> six `bit_valid` pulses; on the 7th strobe `stuff_bit=1`, `bit_valid=0`, `run_cnt=0`.
- Seven decoded 1s with `NRZI_STUFF_CHECK_EN` defined -> `stuff_err` pulse on the 7th strobe, `run_cnt` stays 6; an 8th 1 gives a second `stuff_err`. With the macro undefined -> `stuff_bit` pulse on the 7th strobe, `stuff_err` never asserts.
- `clear` and `shift_en` high in the same cycle with `run_cnt=4` -> no strobe output pulses, `run_cnt=0`; next strobe with `d=IDLE_LEVEL` decodes 1.
- `STUFF_LEN=3` instance: three decoded 1s then a toggle -> `stuff_bit` on the 4th strobe; three 1s then a 1 -> `stuff_err`.

Source files
------------

// File: rtl/nrzi_unstuff_decoder.sv
// USB 1.1 receive NRZI decoder with bit-unstuffing, one bit per shift_en strobe.
// Define NRZI_STUFF_CHECK_EN to flag a 1 in the stuff position as stuff_err.
module nrzi_unstuff_decoder #(
  parameter int unsigned STUFF_LEN  = 6,
  parameter logic        IDLE_LEVEL = 1'b1,
  localparam int unsigned CW        = $clog2(STUFF_LEN + 1)
) (
  input  logic          clk_i,
  input  logic          n_rst_i,
  input  logic          d_i,
  input  logic          shift_en_i,
  input  logic          clear_i,
  output logic          d_orig_o,
  output logic          d_edge_o,
  output logic          bit_valid_o,
  output logic          stuff_bit_o,
  output logic          stuff_err_o,
  output logic [CW-1:0] run_cnt_o
);

  localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);

  logic          q_clk_q, q_clk_d;
  logic          d_edge_q, d_edge_d;
  logic          prev_bit_q, prev_bit_d;
  logic          d_orig_q, d_orig_d;
  logic          bit_valid_q, bit_valid_d;
  logic          stuff_bit_q, stuff_bit_d;
  logic          stuff_err_q, stuff_err_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          dec_bit;

  assign dec_bit = ~(d_i ^ prev_bit_q);

  always_comb begin
    q_clk_d     = d_i;
    d_edge_d    = d_i ^ q_clk_q;
    prev_bit_d  = prev_bit_q;
    d_orig_d    = d_orig_q;
    run_cnt_d   = run_cnt_q;
    bit_valid_d = 1'b0;
    stuff_bit_d = 1'b0;
    stuff_err_d = 1'b0;

    // clear re-arms the NRZI reference and swallows any coincident strobe
    if (clear_i) begin
      prev_bit_d = IDLE_LEVEL;
      run_cnt_d  = '0;
    end else if (shift_en_i) begin
      prev_bit_d = d_i;
      d_orig_d   = dec_bit;
      if (run_cnt_q < STUFF_MAX) begin
        bit_valid_d = 1'b1;
        run_cnt_d   = dec_bit ? run_cnt_q + CW'(1) : '0;
      end else begin
`ifdef NRZI_STUFF_CHECK_EN
        // counter stays saturated so every further 1 is also a violation
        if (dec_bit) begin
          stuff_err_d = 1'b1;
        end else begin
          stuff_bit_d = 1'b1;
          run_cnt_d   = '0;
        end
`else
        stuff_bit_d = 1'b1;
        run_cnt_d   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      q_clk_q     <= IDLE_LEVEL;
      d_edge_q    <= 1'b0;
      prev_bit_q  <= IDLE_LEVEL;
      d_orig_q    <= 1'b0;
      run_cnt_q   <= '0;
      bit_valid_q <= 1'b0;
      stuff_bit_q <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      q_clk_q     <= q_clk_d;
      d_edge_q    <= d_edge_d;
      prev_bit_q  <= prev_bit_d;
      d_orig_q    <= d_orig_d;
      run_cnt_q   <= run_cnt_d;
      bit_valid_q <= bit_valid_d;
      stuff_bit_q <= stuff_bit_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign d_orig_o    = d_orig_q;
  assign d_edge_o    = d_edge_q;
  assign bit_valid_o = bit_valid_q;
  assign stuff_bit_o = stuff_bit_q;
  assign stuff_err_o = stuff_err_q;
  assign run_cnt_o   = run_cnt_q;

endmodule

// File: tb/tb_nrzi_unstuff_decoder.sv
// Directed self-checking bench for nrzi_unstuff_decoder (STUFF_LEN=6 and STUFF_LEN=3 instances).
// Violation expectations follow NRZI_STUFF_CHECK_EN.
module tb_nrzi_unstuff_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRst, d, shiftEn, clear;
  logic       dOrig, dEdge, bitValid, stuffBit, stuffErr;
  logic [2:0] runCnt;

  logic       nRst3, d3, shiftEn3, clear3;
  logic       dOrig3, dEdge3, bitValid3, stuffBit3, stuffErr3;
  logic [1:0] runCnt3;

  int checks = 0;
  int passed = 0;

  nrzi_unstuff_decoder #(.STUFF_LEN(6), .IDLE_LEVEL(1'b1)) dut (
    .clk_i(clk), .n_rst_i(nRst), .d_i(d), .shift_en_i(shiftEn), .clear_i(clear),
    .d_orig_o(dOrig), .d_edge_o(dEdge), .bit_valid_o(bitValid),
    .stuff_bit_o(stuffBit), .stuff_err_o(stuffErr), .run_cnt_o(runCnt)
  );

  nrzi_unstuff_decoder #(.STUFF_LEN(3), .IDLE_LEVEL(1'b1)) dut3 (
    .clk_i(clk), .n_rst_i(nRst3), .d_i(d3), .shift_en_i(shiftEn3), .clear_i(clear3),
    .d_orig_o(dOrig3), .d_edge_o(dEdge3), .bit_valid_o(bitValid3),
    .stuff_bit_o(stuffBit3), .stuff_err_o(stuffErr3), .run_cnt_o(runCnt3)
  );

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic v);
    d = v; shiftEn = 1'b1;
    @(posedge clk); #1;
    shiftEn = 1'b0;
  endtask

  task automatic strobe3(input logic v);
    d3 = v; shiftEn3 = 1'b1;
    @(posedge clk); #1;
    shiftEn3 = 1'b0;
  endtask

  task automatic doReset;
    d = 1'b1; shiftEn = 1'b0; clear = 1'b0; nRst = 1'b0;
    @(posedge clk); #1;
    nRst = 1'b1;
  endtask

  task automatic test_reset;
    d = 1'b1; shiftEn = 1'b1; clear = 1'b1; nRst = 1'b0;
    idle(2);
    shiftEn = 1'b0; clear = 1'b0; nRst = 1'b1;
    checks++; if (dOrig !== 1'b0) $display("[TB] FAIL reset_dorig: got %b exp 0", dOrig); else passed++;
    checks++; if (dEdge !== 1'b0) $display("[TB] FAIL reset_dedge: got %b exp 0", dEdge); else passed++;
    checks++; if (bitValid !== 1'b0) $display("[TB] FAIL reset_bitvalid: got %b exp 0", bitValid); else passed++;
    checks++; if (stuffBit !== 1'b0) $display("[TB] FAIL reset_stuffbit: got %b exp 0", stuffBit); else passed++;
    checks++; if (stuffErr !== 1'b0) $display("[TB] FAIL reset_stufferr: got %b exp 0", stuffErr); else passed++;
    checks++; if (runCnt !== 3'd0) $display("[TB] FAIL reset_runcnt: got %0d exp 0", runCnt); else passed++;
    idle(1);
    checks++; if (dEdge !== 1'b0) $display("[TB] FAIL reset_qclk_idle: got %b exp 0", dEdge); else passed++;
  endtask

  task automatic test_steady_ones;
    for (int i = 1; i <= 3; i++) begin
      idle(3);
      strobe(1'b1);
      checks++; if (dOrig !== 1'b1) $display("[TB] FAIL ones_dorig[%0d]: got %b exp 1", i, dOrig); else passed++;
      checks++; if (bitValid !== 1'b1) $display("[TB] FAIL ones_valid[%0d]: got %b exp 1", i, bitValid); else passed++;
      checks++; if (runCnt !== 3'(i)) $display("[TB] FAIL ones_runcnt[%0d]: got %0d exp %0d", i, runCnt, i); else passed++;
      checks++; if (dEdge !== 1'b0) $display("[TB] FAIL ones_dedge[%0d]: got %b exp 0", i, dEdge); else passed++;
      idle(1);
      checks++; if (bitValid !== 1'b0) $display("[TB] FAIL ones_valid_drop[%0d]: got %b exp 0", i, bitValid); else passed++;
    end
  endtask

  task automatic test_nrzi_pattern;
    logic lineSeq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic expBit  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic expEdge [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] expRun [4] = '{3'd1, 3'd0, 3'd1, 3'd0};
    doReset();
    for (int i = 0; i < 4; i++) begin
      strobe(lineSeq[i]);
      checks++; if (dOrig !== expBit[i]) $display("[TB] FAIL nrzi_dorig[%0d]: got %b exp %b", i, dOrig, expBit[i]); else passed++;
      checks++; if (bitValid !== 1'b1) $display("[TB] FAIL nrzi_valid[%0d]: got %b exp 1", i, bitValid); else passed++;
      checks++; if (runCnt !== expRun[i]) $display("[TB] FAIL nrzi_runcnt[%0d]: got %0d exp %0d", i, runCnt, expRun[i]); else passed++;
      checks++; if (dEdge !== expEdge[i]) $display("[TB] FAIL nrzi_dedge[%0d]: got %b exp %b", i, dEdge, expEdge[i]); else passed++;
      idle(1);
      checks++; if (dEdge !== 1'b0) $display("[TB] FAIL nrzi_dedge_drop[%0d]: got %b exp 0", i, dEdge); else passed++;
    end
  endtask

  task automatic test_stuff_bit;
    doReset();
    for (int i = 1; i <= 6; i++) begin
      strobe(1'b1);
      checks++; if (bitValid !== 1'b1) $display("[TB] FAIL stuff_valid[%0d]: got %b exp 1", i, bitValid); else passed++;
      checks++; if (runCnt !== 3'(i)) $display("[TB] FAIL stuff_runcnt[%0d]: got %0d exp %0d", i, runCnt, i); else passed++;
    end
    strobe(1'b0);
    checks++; if (stuffBit !== 1'b1) $display("[TB] FAIL stuff_pulse: got %b exp 1", stuffBit); else passed++;
    checks++; if (bitValid !== 1'b0) $display("[TB] FAIL stuff_novalid: got %b exp 0", bitValid); else passed++;
    checks++; if (stuffErr !== 1'b0) $display("[TB] FAIL stuff_noerr: got %b exp 0", stuffErr); else passed++;
    checks++; if (runCnt !== 3'd0) $display("[TB] FAIL stuff_runcnt_clr: got %0d exp 0", runCnt); else passed++;
    checks++; if (dOrig !== 1'b0) $display("[TB] FAIL stuff_dorig: got %b exp 0", dOrig); else passed++;
    idle(1);
    checks++; if (stuffBit !== 1'b0) $display("[TB] FAIL stuff_pulse_drop: got %b exp 0", stuffBit); else passed++;
  endtask

  task automatic test_stuff_violation;
    doReset();
    repeat (6) strobe(1'b1);
    checks++; if (runCnt !== 3'd6) $display("[TB] FAIL viol_pre_runcnt: got %0d exp 6", runCnt); else passed++;
    strobe(1'b1);
    checks++; if (bitValid !== 1'b0) $display("[TB] FAIL viol7_novalid: got %b exp 0", bitValid); else passed++;
`ifdef NRZI_STUFF_CHECK_EN
    checks++; if (stuffErr !== 1'b1) $display("[TB] FAIL viol7_err: got %b exp 1", stuffErr); else passed++;
    checks++; if (stuffBit !== 1'b0) $display("[TB] FAIL viol7_nostuff: got %b exp 0", stuffBit); else passed++;
    checks++; if (runCnt !== 3'd6) $display("[TB] FAIL viol7_runcnt: got %0d exp 6", runCnt); else passed++;
    strobe(1'b1);
    checks++; if (stuffErr !== 1'b1) $display("[TB] FAIL viol8_err: got %b exp 1", stuffErr); else passed++;
    checks++; if (bitValid !== 1'b0) $display("[TB] FAIL viol8_novalid: got %b exp 0", bitValid); else passed++;
    checks++; if (runCnt !== 3'd6) $display("[TB] FAIL viol8_runcnt: got %0d exp 6", runCnt); else passed++;
`else
    checks++; if (stuffErr !== 1'b0) $display("[TB] FAIL viol7_noerr: got %b exp 0", stuffErr); else passed++;
    checks++; if (stuffBit !== 1'b1) $display("[TB] FAIL viol7_stuff: got %b exp 1", stuffBit); else passed++;
    checks++; if (runCnt !== 3'd0) $display("[TB] FAIL viol7_runcnt: got %0d exp 0", runCnt); else passed++;
    strobe(1'b1);
    checks++; if (stuffErr !== 1'b0) $display("[TB] FAIL viol8_noerr: got %b exp 0", stuffErr); else passed++;
    checks++; if (bitValid !== 1'b1) $display("[TB] FAIL viol8_valid: got %b exp 1", bitValid); else passed++;
    checks++; if (runCnt !== 3'd1) $display("[TB] FAIL viol8_runcnt: got %0d exp 1", runCnt); else passed++;
`endif
  endtask

  task automatic test_clear_collision;
    doReset();
    strobe(1'b0);
    repeat (4) strobe(1'b0);
    checks++; if (runCnt !== 3'd4) $display("[TB] FAIL clr_pre_runcnt: got %0d exp 4", runCnt); else passed++;
    checks++; if (dOrig !== 1'b1) $display("[TB] FAIL clr_pre_dorig: got %b exp 1", dOrig); else passed++;
    d = 1'b1; shiftEn = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    shiftEn = 1'b0; clear = 1'b0;
    checks++; if (bitValid !== 1'b0) $display("[TB] FAIL clr_novalid: got %b exp 0", bitValid); else passed++;
    checks++; if (stuffBit !== 1'b0) $display("[TB] FAIL clr_nostuff: got %b exp 0", stuffBit); else passed++;
    checks++; if (stuffErr !== 1'b0) $display("[TB] FAIL clr_noerr: got %b exp 0", stuffErr); else passed++;
    checks++; if (runCnt !== 3'd0) $display("[TB] FAIL clr_runcnt: got %0d exp 0", runCnt); else passed++;
    checks++; if (dOrig !== 1'b1) $display("[TB] FAIL clr_dorig_hold: got %b exp 1", dOrig); else passed++;
    strobe(1'b1);
    checks++; if (dOrig !== 1'b1) $display("[TB] FAIL clr_post_dorig: got %b exp 1", dOrig); else passed++;
    checks++; if (bitValid !== 1'b1) $display("[TB] FAIL clr_post_valid: got %b exp 1", bitValid); else passed++;
    checks++; if (runCnt !== 3'd1) $display("[TB] FAIL clr_post_runcnt: got %0d exp 1", runCnt); else passed++;
  endtask

  task automatic test_reset_mid_packet;
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b0);
    checks++; if (runCnt !== 3'd2) $display("[TB] FAIL midrst_pre_runcnt: got %0d exp 2", runCnt); else passed++;
    d = 1'b0; shiftEn = 1'b1; clear = 1'b1; nRst = 1'b0;
    @(posedge clk); #1;
    shiftEn = 1'b0; clear = 1'b0; nRst = 1'b1;
    checks++; if (runCnt !== 3'd0) $display("[TB] FAIL midrst_runcnt: got %0d exp 0", runCnt); else passed++;
    checks++; if (bitValid !== 1'b0) $display("[TB] FAIL midrst_novalid: got %b exp 0", bitValid); else passed++;
    checks++; if (dOrig !== 1'b0) $display("[TB] FAIL midrst_dorig: got %b exp 0", dOrig); else passed++;
    strobe(1'b1);
    checks++; if (dOrig !== 1'b1) $display("[TB] FAIL midrst_post_dorig: got %b exp 1", dOrig); else passed++;
    checks++; if (runCnt !== 3'd1) $display("[TB] FAIL midrst_post_runcnt: got %0d exp 1", runCnt); else passed++;
  endtask

  task automatic test_stuff_len3;
    d3 = 1'b1; shiftEn3 = 1'b0; clear3 = 1'b0; nRst3 = 1'b0;
    @(posedge clk); #1;
    nRst3 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      strobe3(1'b1);
      checks++; if (runCnt3 !== 2'(i)) $display("[TB] FAIL len3a_runcnt[%0d]: got %0d exp %0d", i, runCnt3, i); else passed++;
    end
    strobe3(1'b0);
    checks++; if (stuffBit3 !== 1'b1) $display("[TB] FAIL len3_stuff: got %b exp 1", stuffBit3); else passed++;
    checks++; if (bitValid3 !== 1'b0) $display("[TB] FAIL len3_novalid: got %b exp 0", bitValid3); else passed++;
    checks++; if (runCnt3 !== 2'd0) $display("[TB] FAIL len3_runcnt_clr: got %0d exp 0", runCnt3); else passed++;
    for (int i = 1; i <= 3; i++) begin
      strobe3(1'b0);
      checks++; if (bitValid3 !== 1'b1) $display("[TB] FAIL len3b_valid[%0d]: got %b exp 1", i, bitValid3); else passed++;
    end
    strobe3(1'b0);
    checks++; if (bitValid3 !== 1'b0) $display("[TB] FAIL len3_viol_novalid: got %b exp 0", bitValid3); else passed++;
`ifdef NRZI_STUFF_CHECK_EN
    checks++; if (stuffErr3 !== 1'b1) $display("[TB] FAIL len3_err: got %b exp 1", stuffErr3); else passed++;
    checks++; if (runCnt3 !== 2'd3) $display("[TB] FAIL len3_err_runcnt: got %0d exp 3", runCnt3); else passed++;
`else
    checks++; if (stuffErr3 !== 1'b0) $display("[TB] FAIL len3_noerr: got %b exp 0", stuffErr3); else passed++;
    checks++; if (stuffBit3 !== 1'b1) $display("[TB] FAIL len3_viol_stuff: got %b exp 1", stuffBit3); else passed++;
    checks++; if (runCnt3 !== 2'd0) $display("[TB] FAIL len3_viol_runcnt: got %0d exp 0", runCnt3); else passed++;
`endif
  endtask

  initial begin
    nRst = 1'b0; d = 1'b1; shiftEn = 1'b0; clear = 1'b0;
    nRst3 = 1'b0; d3 = 1'b1; shiftEn3 = 1'b0; clear3 = 1'b0;
    test_reset();
    test_steady_ones();
    test_nrzi_pattern();
    test_stuff_bit();
    test_stuff_violation();
    test_clear_collision();
    test_reset_mid_packet();
    test_stuff_len3();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
